// File: rtl/calc_pkg.sv
// Shared calculator display definitions.
// Holds the 7-segment codes ({g,f,e,d,c,b,a}, active-high), the conversion
// FSM state type and the digit positions of the 3-digit result display.
package calc_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_SIGN  = 2'd2;

endpackage

// File: rtl/calc_result_display_if.sv
// Result-to-display bundle.
//   number_in/op_selected/load : result word, operation flag and load strobe
//   busy/done                  : conversion status back to the producer
//   an/seg                     : multiplexed 7-segment drive
// master = result producer side, slave = display block.
interface calc_result_display_if;
  logic [4:0] number_in;
  logic       op_selected;
  logic       load;
  logic       busy;
  logic       done;
  logic [2:0] an;
  logic [6:0] seg;

  modport master (
    output number_in, op_selected, load,
    input  busy, done, an, seg
  );

  modport slave (
    input  number_in, op_selected, load,
    output busy, done, an, seg
  );
endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational 4-bit to 7-segment decoder with blanking.
//   digit : value 0..9 (10..15 decode to blank)
//   blank : force all segments off
//   seg   : {g,f,e,d,c,b,a}, active-high
module seg7_digit_decode
  import calc_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/calc_result_display.sv
// Calculator result display.
// Captures a 5-bit add/sub result on load, converts it to sign/tens/units by
// repeated subtraction of 10 (one cycle per tens step plus one finishing
// cycle), then commits it to the display registers in a single edge so the
// multiplexed scan never shows a half-converted value.
// Ports:
//   clk   : system clock
//   clear : synchronous active-high reset, overrides load
//   bus   : calc_result_display_if.slave (result in, busy/done, an/seg out)
module calc_result_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  clear,
  calc_result_display_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  state_t        state_q, state_d;
  logic [4:0]    mag_q, mag_d;
  logic [1:0]    tens_work_q, tens_work_d;
  logic          neg_work_q, neg_work_d;
  logic [3:0]    units_q, units_d;
  logic [1:0]    tens_q, tens_d;
  logic          shown_neg_q, shown_neg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    scan_idx_q, scan_idx_d;
  logic          capture_neg;

  // Conversion FSM and display commit.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    tens_work_d = tens_work_q;
    neg_work_d  = neg_work_q;
    units_d     = units_q;
    tens_d      = tens_q;
    shown_neg_d = shown_neg_q;
    done_d      = 1'b0;
    capture_neg = bus.op_selected & bus.number_in[4];

    if (bus.load) begin
      // A new load always wins, also over a conversion in progress.
      neg_work_d  = capture_neg;
      mag_d       = capture_neg ? (~bus.number_in + 5'd1) : bus.number_in;
      tens_work_d = 2'd0;
      state_d     = CONV;
    end else if (state_q == CONV) begin
      if (mag_q >= 5'd10) begin
        mag_d       = mag_q - 5'd10;
        tens_work_d = tens_work_q + 2'd1;
      end else begin
        units_d     = mag_q[3:0];
        tens_d      = tens_work_q;
        shown_neg_d = neg_work_q;
        state_d     = IDLE;
        done_d      = 1'b1;
      end
    end

    busy_d = (state_d == CONV);
  end

  // Digit scan, free-running and independent of the FSM.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    scan_idx_d    = scan_idx_q;
    if (refresh_cnt_q == CNT_LAST) begin
      refresh_cnt_d = '0;
      scan_idx_d    = (scan_idx_q == DIG_SIGN) ? DIG_UNITS : scan_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= IDLE;
      mag_q         <= '0;
      tens_work_q   <= '0;
      neg_work_q    <= 1'b0;
      units_q       <= '0;
      tens_q        <= '0;
      shown_neg_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      refresh_cnt_q <= '0;
      scan_idx_q    <= DIG_UNITS;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      tens_work_q   <= tens_work_d;
      neg_work_q    <= neg_work_d;
      units_q       <= units_d;
      tens_q        <= tens_d;
      shown_neg_q   <= shown_neg_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      refresh_cnt_q <= refresh_cnt_d;
      scan_idx_q    <= scan_idx_d;
    end
  end

  // Output decode: one shared numeric decoder, sign digit handled directly.
  logic [3:0] dec_digit;
  logic       dec_blank;
  logic [6:0] dec_seg;

  assign dec_digit = (scan_idx_q == DIG_TENS) ? {2'b00, tens_q} : units_q;
  assign dec_blank = (scan_idx_q == DIG_TENS) && (tens_q == 2'd0);

  seg7_digit_decode u_dec (
    .digit (dec_digit),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  assign bus.seg  = (scan_idx_q == DIG_SIGN) ? (shown_neg_q ? SEG_MINUS : SEG_BLANK)
                                             : dec_seg;
  assign bus.an   = 3'b001 << scan_idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/calc_result_display.md
Name: calc_result_display

Overview:
- Display-side consumer of the calculator result. It captures the registered 5-bit add/subtract result and its operation flag on a load strobe.
- A small sequential FSM converts the value to sign/tens/units, while the previous value stays on the display.
- Drives a 3-digit multiplexed 7-segment display: digit 2 = sign, digit 1 = tens, digit 0 = units.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is enabled before the scan advances; minimum 1.

Ports:
- clk  in  1  system clock, rising-edge.
- clear  in  1  reset, synchronous, active-high.
- number_in  in  5  result word: unsigned sum 0..30 when op_selected=0; two's-complement difference -15..+15 when op_selected=1.
- op_selected  in  1  0 = addition result, 1 = subtraction result; sampled with load.
- load  in  1  one-cycle strobe, number_in/op_selected valid.
- busy  out  1  high while conversion is in progress.
- done  out  1  one-cycle pulse when the new value reaches the display.
- an  out  3  one-hot digit enable, active-high; an[0] = units.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.

Behaviour:
- Clock and reset: single clock domain. clear is synchronous and active-high, and overrides load.
- Reset values: FSM=IDLE; shown value = +0 (units 0, tens 0, neg 0); scan_idx=0; refresh_cnt=0; busy=0; done=0; an=3'b001; seg=7'h3F.
- Capture (edge where load=1):
  - neg = op_selected & number_in[4].
  - mag = neg ? (~number_in + 1) : number_in; mag is 5-bit, range 0..30.
  - tens_work=0; enter CONV.
  - A subtraction result of 0 gives neg=0, so no "-0" is shown.
- FSM IDLE: busy=0; wait for load.
- FSM CONV: busy=1. On each edge:
  - if mag_work>=10: mag_work-=10, tens_work+=1.
  - else: copy units=mag_work[3:0], tens=tens_work, shown_neg=neg into the display registers; go to IDLE; done=1 for exactly the next cycle.
- Latency: load accepted at edge N; display registers updated at edge N+tens+1; done high for the cycle after that edge.
  - Value 30: 4 CONV cycles. Value 7: 1 CONV cycle.
- load during CONV: restart capture with the new value (latest wins); no done for the aborted value.
- Display registers change only at conversion completion or on clear. The scan never shows partial values.
- Scan:
  - refresh_cnt counts 0..REFRESH_DIV-1.
  - At the wrap edge, scan_idx advances 0→1→2→0 and refresh_cnt returns to 0.
  - The scan runs independently of the FSM and is not reset by load.
- Outputs an and seg decode combinationally from registered scan_idx and display registers:
  - an = 1<<scan_idx.
  - Digit 0: units, always shown.
  - Digit 1: tens; blanked (seg=0) when tens==0.
  - Digit 2: seg=7'h40 (minus) if shown_neg, else blanked.
- Segment codes 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- REFRESH_DIV=1: scan advances every cycle.
- clear mid-CONV: aborts; busy=0, done=0, display returns to +0.
- number_in[4]=1 with op_selected=0: legal unsigned 16..30.

Decomposition:
- Shared package calc_pkg:
  - SEG_DIGIT[0:9] constants, SEG_MINUS=7'h40, SEG_BLANK=7'h00.
  - FSM state typedef {IDLE, CONV}.
  - Digit index constants DIG_UNITS=0, DIG_TENS=1, DIG_SIGN=2.
- One natural sub-module: seg7_digit_decode, a combinational 4-bit → 7-seg decoder with blank input, reused by other calculator displays.
- The scan counter stays inline.

Test Plan:
- Reset: hold clear 2 cycles → an=001, seg=3F, busy=0, done=0; with REFRESH_DIV=4, an sequence 001×4, 010×4, 100×4, 001; tens and sign digits show seg=00.
- Add max: number_in=5'b11110, op_selected=0, load → busy 4 cycles, then done pulse; units seg=3F, tens seg=4F, sign seg=00.
- Subtract min: number_in=5'b10001, op_selected=1 → busy 2 cycles; units seg=6D, tens seg=06, sign seg=40.
- Small and zero values:
  - number_in=5'b00111, op_selected=0 → 1 CONV cycle; units seg=07, tens and sign blank.
  - number_in=5'b00000, op_selected=1 → units seg=3F, no minus.
- Reload mid-conversion: load 30, then load 5'b00101 (op 0) two cycles later → display never shows 30; exactly one done; final units seg=6D, tens blank.
- clear mid-CONV after value -12 is displayed: load 30, assert clear on the 2nd CONV cycle → busy=0 next cycle, no done, display +0 (units 3F, others blank).
